// File: rtl/obi_pkg.sv
// OBI request/response payload types shared by the core ports and memory-side responders.
package obi_pkg;

  localparam int unsigned OBI_AW  = 32;
  localparam int unsigned OBI_DW  = 32;
  localparam int unsigned OBI_BEW = OBI_DW / 8;

  typedef struct packed {
    logic               req;
    logic               we;
    logic [OBI_BEW-1:0] be;
    logic [OBI_AW-1:0]  addr;
    logic [OBI_DW-1:0]  wdata;
  } obi_req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [OBI_DW-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_rsp_delay.sv
// Fixed-depth shift line carrying {valid,data} response words; reset flushes every stage.
module obi_rsp_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 33
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory responder: word-addressed RAM, programmable grant stall and
// fixed-latency in-order response pipeline.
module obi_mem_responder
  import obi_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = 1024,
  parameter int unsigned GNT_WAIT    = 0,
  parameter int unsigned RSP_LATENCY = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  obi_req_t                        obi_req_i,
  output obi_resp_t                       obi_resp_o,
  output logic [$clog2(RSP_LATENCY+1):0]  outstanding_o
);

  localparam int unsigned AW  = $clog2(NUM_WORDS);
  localparam int unsigned WCW = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
  localparam int unsigned OW  = $clog2(RSP_LATENCY + 1) + 1;
  localparam int unsigned PW  = OBI_DW + 1;

  logic [OBI_DW-1:0] r_mem [NUM_WORDS];
  logic [WCW-1:0]    r_wait_cnt;
  logic [WCW-1:0]    w_wait_cnt_nxt;
  logic [OW-1:0]     r_outstanding;
  logic [OW-1:0]     w_outstanding_nxt;
  logic              w_gnt;
  logic              w_rvalid;
  logic [AW-1:0]     w_idx;
  logic [OBI_DW-1:0] w_rd_word;
  logic [PW-1:0]     w_pipe_in;
  logic [PW-1:0]     w_pipe_out;
  logic              w_unused_addr;

  assign w_idx         = obi_req_i.addr[AW+1:2];
  assign w_unused_addr = ^{obi_req_i.addr[OBI_AW-1:AW+2], obi_req_i.addr[1:0]};
  assign w_gnt         = obi_req_i.req && (r_wait_cnt == WCW'(GNT_WAIT));
  assign w_rvalid      = w_pipe_out[PW-1];

  // Stall counter and outstanding count next-state
  always_comb begin
    w_wait_cnt_nxt    = '0;
    w_outstanding_nxt = r_outstanding;
    if (obi_req_i.req && !w_gnt) w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
    if (w_gnt && !w_rvalid)      w_outstanding_nxt = r_outstanding + OW'(1);
    else if (!w_gnt && w_rvalid) w_outstanding_nxt = r_outstanding - OW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait_cnt    <= '0;
      r_outstanding <= '0;
    end else begin
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_outstanding <= w_outstanding_nxt;
    end
  end

  // Byte-lane writes with no reset so the array maps onto SRAM
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < OBI_BEW; i++) begin
      if (w_gnt && obi_req_i.we && obi_req_i.be[i])
        r_mem[w_idx][8*i +: 8] <= obi_req_i.wdata[8*i +: 8];
    end
  end

  // Read data is captured from the pre-write array contents at the grant edge
  assign w_rd_word = r_mem[w_idx];
  assign w_pipe_in = {w_gnt, (w_gnt && !obi_req_i.we) ? w_rd_word : OBI_DW'(0)};

  obi_rsp_delay #(
    .DEPTH (RSP_LATENCY),
    .WIDTH (PW)
  ) u_rsp_delay (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_d   (w_pipe_in),
    .o_q   (w_pipe_out)
  );

  assign obi_resp_o.gnt    = w_gnt;
  assign obi_resp_o.rvalid = w_rvalid;
  assign obi_resp_o.rdata  = w_pipe_out[OBI_DW-1:0];
  assign outstanding_o     = r_outstanding;

  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (obi_req_i.req && !w_gnt) |=>
      $stable({obi_req_i.we, obi_req_i.be, obi_req_i.addr, obi_req_i.wdata}));

  a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
    (obi_req_i.req && !w_gnt) |=> obi_req_i.req);

  a_rdata_zero: assert property (@(posedge clk_i) disable iff (rst_i)
    !obi_resp_o.rvalid |-> (obi_resp_o.rdata == '0));

endmodule
